dp_bram: RTL and testbench

// Parametrised simple-dual-port block RAM: one read port, one byte-enabled write port, on a single clock.

---
 rtl/dp_bram.sv | 136 +++++++++++++
 tb/tb_dp_bram.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dp_bram.sv
// Simple-dual-port RAM: one read port, one byte-enabled write port, one clock.
// Features: optional output register, read-valid strobe and a clear engine.
module dp_bram #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned ADDR_W     = 8,
  parameter string       INIT_FILE  = "",
  parameter bit          OUT_REG    = 1'b0,
  parameter bit          CLR_ON_RST = 1'b0
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                rd_en_i,
  input  logic [ADDR_W-1:0]   rd_addr_i,
  output logic [DATA_W-1:0]   rd_data_o,
  output logic                rd_valid_o,
  input  logic                wr_en_i,
  input  logic [ADDR_W-1:0]   wr_addr_i,
  input  logic [DATA_W-1:0]   wr_data_i,
  input  logic [DATA_W/8-1:0] wr_be_i,
  input  logic                clr_i,
  output logic                busy_o
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned BE_W  = DATA_W / 8;

  typedef enum logic {IDLE, CLEAR} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                start_q, start_d;
  logic                clr_we;
  logic                wr_fire;
  logic [DATA_W-1:0]   rd_word;
  logic [DATA_W-1:0]   rd1_q, rd1_d;
  logic                v1_q, v1_d;

  logic [DATA_W-1:0]   mem [DEPTH];

  // start_q carries a one-shot auto-clear request out of reset
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    start_d = 1'b0;
    clr_we  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (clr_i || start_q) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        clr_we = 1'b1;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == '1) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      start_q <= CLR_ON_RST;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      start_q <= start_d;
    end
  end

  assign busy_o  = (state_q == CLEAR);
  assign wr_fire = wr_en_i && (state_q == IDLE);

  always_ff @(posedge clk_i) begin
    if (clr_we) begin
      mem[cnt_q] <= '0;
    end else if (wr_fire) begin
      for (int unsigned b = 0; b < BE_W; b++) begin
        if (wr_be_i[b]) mem[wr_addr_i][8*b +: 8] <= wr_data_i[8*b +: 8];
      end
    end
  end

  // Write-first: enabled bytes of a same-address write bypass the array
  always_comb begin
    rd_word = mem[rd_addr_i];
    if (wr_fire && (wr_addr_i == rd_addr_i)) begin
      for (int unsigned b = 0; b < BE_W; b++) begin
        if (wr_be_i[b]) rd_word[8*b +: 8] = wr_data_i[8*b +: 8];
      end
    end
    if (state_q == CLEAR) rd_word = '0;
    rd1_d = rd_en_i ? rd_word : rd1_q;
    v1_d  = rd_en_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd1_q <= '0;
      v1_q  <= 1'b0;
    end else begin
      rd1_q <= rd1_d;
      v1_q  <= v1_d;
    end
  end

  if (OUT_REG) begin : g_out_reg
    logic [DATA_W-1:0] rd2_q, rd2_d;
    logic              v2_q, v2_d;

    always_comb begin
      rd2_d = v1_q ? rd1_q : rd2_q;
      v2_d  = v1_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        rd2_q <= '0;
        v2_q  <= 1'b0;
      end else begin
        rd2_q <= rd2_d;
        v2_q  <= v2_d;
      end
    end

    assign rd_data_o  = rd2_q;
    assign rd_valid_o = v2_q;
  end else begin : g_no_out_reg
    assign rd_data_o  = rd1_q;
    assign rd_valid_o = v1_q;
  end

endmodule

// File: tb/tb_dp_bram.sv
// Bench for dp_bram: two instances (latency 1 and 2) on shared stimulus, checked every cycle
// against an array-based reference model, plus hand-computed expectations for key scenarios.
module tb_dp_bram;

    logic        clk;
    logic        rst_ni;
    logic        rd_en;
    logic [7:0]  rd_addr;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [15:0] wr_data;
    logic [1:0]  wr_be;
    logic        clr;

    logic [15:0] d0_data, d1_data;
    logic        d0_valid, d1_valid, d0_busy, d1_busy;

    int tests = 0;
    int fails = 0;

    dp_bram #(.DATA_W(16), .ADDR_W(8), .OUT_REG(1'b0), .CLR_ON_RST(1'b0)) dut0 (
        .clk_i(clk), .rst_ni(rst_ni), .rd_en_i(rd_en), .rd_addr_i(rd_addr),
        .rd_data_o(d0_data), .rd_valid_o(d0_valid), .wr_en_i(wr_en), .wr_addr_i(wr_addr),
        .wr_data_i(wr_data), .wr_be_i(wr_be), .clr_i(clr), .busy_o(d0_busy)
    );

    dp_bram #(.DATA_W(16), .ADDR_W(8), .OUT_REG(1'b1), .CLR_ON_RST(1'b0)) dut1 (
        .clk_i(clk), .rst_ni(rst_ni), .rd_en_i(rd_en), .rd_addr_i(rd_addr),
        .rd_data_o(d1_data), .rd_valid_o(d1_valid), .wr_en_i(wr_en), .wr_addr_i(wr_addr),
        .wr_data_i(wr_data), .wr_be_i(wr_be), .clr_i(clr), .busy_o(d1_busy)
    );

    always #5 clk = ~clk;

    // Reference model: plain array, a busy flag with a sweep pointer, and delay stages
    logic [15:0] m_mem [256];
    logic        m_busy;
    int          m_ptr;
    logic [15:0] m_w, m_r;
    logic [15:0] e0_d, e1_d, p_d;
    logic        e0_v, e1_v, p_v;

    always_comb begin
        m_w = m_mem[wr_addr];
        if (wr_be[0]) m_w[7:0]  = wr_data[7:0];
        if (wr_be[1]) m_w[15:8] = wr_data[15:8];
        if (m_busy) m_r = 16'h0000;
        else if (wr_en && wr_addr == rd_addr) m_r = m_w;
        else m_r = m_mem[rd_addr];
    end

    always @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            m_busy <= 1'b0;
            m_ptr  <= 0;
            e0_d <= '0; e0_v <= 1'b0;
            p_d  <= '0; p_v  <= 1'b0;
            e1_d <= '0; e1_v <= 1'b0;
        end else begin
            if (m_busy) begin
                m_mem[m_ptr] <= 16'h0000;
                if (m_ptr == 255) begin
                    m_busy <= 1'b0;
                    m_ptr  <= 0;
                end else begin
                    m_ptr <= m_ptr + 1;
                end
            end else begin
                if (wr_en) m_mem[wr_addr] <= m_w;
                if (clr) begin
                    m_busy <= 1'b1;
                    m_ptr  <= 0;
                end
            end
            e0_v <= rd_en;
            if (rd_en) e0_d <= m_r;
            p_v <= rd_en;
            if (rd_en) p_d <= m_r;
            e1_v <= p_v;
            if (p_v) e1_d <= p_d;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        chk("busy0", {31'd0, d0_busy}, {31'd0, m_busy});
        chk("busy1", {31'd0, d1_busy}, {31'd0, m_busy});
        chk("valid0", {31'd0, d0_valid}, {31'd0, e0_v});
        chk("valid1", {31'd0, d1_valid}, {31'd0, e1_v});
        chk("data0", {16'd0, d0_data}, {16'd0, e0_d});
        chk("data1", {16'd0, d1_data}, {16'd0, e1_d});
    endtask

    task automatic cyc(input logic re, input logic [7:0] ra, input logic we, input logic [7:0] wa,
                       input logic [15:0] wd, input logic [1:0] be, input logic c);
        rd_en = re; rd_addr = ra; wr_en = we; wr_addr = wa; wr_data = wd; wr_be = be; clr = c;
        step();
    endtask

    task automatic idle();
        cyc(1'b0, 8'h00, 1'b0, 8'h00, 16'h0000, 2'b00, 1'b0);
    endtask

    task automatic rd(input logic [7:0] a);
        cyc(1'b1, a, 1'b0, 8'h00, 16'h0000, 2'b00, 1'b0);
    endtask

    task automatic wr(input logic [7:0] a, input logic [15:0] d, input logic [1:0] be);
        cyc(1'b0, 8'h00, 1'b1, a, d, be, 1'b0);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (d0_busy && n < 300) begin
            n++;
            idle();
        end
        chk("wait_idle", {31'd0, d0_busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        clk = 1'b0; rst_ni = 1'b1;
        rd_en = 1'b0; rd_addr = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0; clr = 1'b0;
        #2 rst_ni = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_data0", {16'd0, d0_data}, 32'd0);
        chk("rst_valid0", {31'd0, d0_valid}, 32'd0);
        chk("rst_busy0", {31'd0, d0_busy}, 32'd0);
        chk("rst_data1", {16'd0, d1_data}, 32'd0);
        chk("rst_valid1", {31'd0, d1_valid}, 32'd0);
        rst_ni = 1'b1;

        // Full clear: length, dropped write, zeroed reads
        cyc(1'b0, 8'h00, 1'b0, 8'h00, 16'h0000, 2'b00, 1'b1);
        n = 0;
        while (d0_busy && n < 300) begin
            n++;
            if (n == 50) cyc(1'b1, 8'h05, 1'b1, 8'h05, 16'hFFFF, 2'b11, 1'b0);
            else cyc(1'b1, n[7:0], 1'b0, 8'h00, 16'h0000, 2'b00, 1'b0);
        end
        chk("clr_len", n, 32'd256);
        for (int a = 0; a < 256; a++) rd(a[7:0]);
        rd(8'h05);
        chk("clr_drop", {16'd0, d0_data}, 32'h0000);

        // Write then read
        wr(8'h10, 16'hBEEF, 2'b11);
        rd(8'h10);
        chk("t1_data0", {16'd0, d0_data}, 32'hBEEF);
        chk("t1_valid0", {31'd0, d0_valid}, 32'd1);
        idle();
        chk("t1_data1", {16'd0, d1_data}, 32'hBEEF);
        chk("t1_valid1", {31'd0, d1_valid}, 32'd1);
        chk("t1_valid0_off", {31'd0, d0_valid}, 32'd0);

        // Same-cycle read/write with byte merge
        wr(8'h20, 16'h1234, 2'b11);
        cyc(1'b1, 8'h20, 1'b1, 8'h20, 16'hAB00, 2'b10, 1'b0);
        chk("t2_bypass", {16'd0, d0_data}, 32'hAB34);
        rd(8'h20);
        chk("t2_later", {16'd0, d0_data}, 32'hAB34);
        wr(8'h20, 16'h5555, 2'b00);
        rd(8'h20);
        chk("t2_be0", {16'd0, d0_data}, 32'hAB34);

        // Back-to-back reads through the latency-2 instance
        wr(8'h00, 16'h1111, 2'b11);
        wr(8'h01, 16'h2222, 2'b11);
        wr(8'h02, 16'h3333, 2'b11);
        idle();
        rd(8'h00);
        chk("t3_v_k0", {31'd0, d1_valid}, 32'd0);
        rd(8'h01);
        chk("t3_k1", {15'd0, d1_valid, d1_data}, 32'h1_1111);
        rd(8'h02);
        chk("t3_k2", {15'd0, d1_valid, d1_data}, 32'h1_2222);
        idle();
        chk("t3_k3", {15'd0, d1_valid, d1_data}, 32'h1_3333);
        idle();
        chk("t3_k4", {15'd0, d1_valid, d1_data}, 32'h0_3333);

        // Random traffic with collisions and occasional clears
        for (int i = 0; i < 700; i++) begin
            logic [7:0] ra, wa;
            wa = ($urandom % 2 == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom % 256);
            ra = ($urandom % 3 == 0) ? wa : 8'($urandom_range(0, 15));
            cyc(1'($urandom % 2), ra, 1'($urandom % 2), wa, 16'($urandom), 2'($urandom % 4),
                1'($urandom % 250 == 0));
        end
        wait_idle();

        // Reset abort mid-clear
        wr(8'd200, 16'hC0DE, 2'b11);
        wr(8'd50, 16'h7777, 2'b11);
        wr(8'd150, 16'h4242, 2'b11);
        cyc(1'b0, 8'h00, 1'b0, 8'h00, 16'h0000, 2'b00, 1'b1);
        repeat (100) idle();
        rst_ni = 1'b0;
        #1;
        chk("abort_busy0", {31'd0, d0_busy}, 32'd0);
        chk("abort_busy1", {31'd0, d1_busy}, 32'd0);
        chk("abort_data0", {15'd0, d0_valid, d0_data}, 32'd0);
        chk("abort_data1", {15'd0, d1_valid, d1_data}, 32'd0);
        @(negedge clk);
        step();
        rst_ni = 1'b1;
        idle();
        chk("rst_hold", {16'd0, d0_data}, 32'd0);
        for (int a = 0; a < 256; a++) rd(a[7:0]);
        rd(8'd99);
        chk("abort_w99", {16'd0, d0_data}, 32'h0000);
        rd(8'd50);
        chk("abort_w50", {16'd0, d0_data}, 32'h0000);
        rd(8'd150);
        chk("abort_w150", {16'd0, d0_data}, 32'h4242);
        rd(8'd200);
        chk("abort_w200", {16'd0, d0_data}, 32'hC0DE);

        // Idle cycles hold the last read result
        repeat (3) idle();
        chk("hold_data0", {15'd0, d0_valid, d0_data}, 32'h0_C0DE);
        chk("hold_data1", {15'd0, d1_valid, d1_data}, 32'h0_C0DE);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
